// File: rtl/fpu_result_skid_buffer_if.sv
// -----------------------------------------------------------------------------
// fpu_result_skid_buffer_if
//   Bundles the two valid/ready handshakes of the FPU result skid buffer,
//   plus its occupancy and protocol-error status.
//
//   Handshake rule (both sides): a transfer happens on a rising clock edge
//   where valid and ready are both 1. A producer holds valid and its payload
//   stable until the transfer happens. Ready may change freely and is never a
//   function of valid in the same cycle.
//
//   Signals:
//     in_valid/in_ready/in_data/in_flags      FPU core -> buffer
//     out_valid/out_ready/out_data/out_flags  buffer -> consumer
//     count      occupancy 0..2
//     proto_err  sticky flag: upstream withdrew in_valid while stalled
//
//   Modports:
//     slave  - the buffer itself
//     master - the environment (FPU core plus consumer)
// -----------------------------------------------------------------------------
interface fpu_result_skid_buffer_if #(
  parameter int WIDTH  = 32,
  parameter int FLAG_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [FLAG_W-1:0] in_flags;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [FLAG_W-1:0] out_flags;
  logic [1:0]        count;
  logic              proto_err;

  modport slave (
    input  in_valid, in_data, in_flags, out_ready,
    output in_ready, out_valid, out_data, out_flags, count, proto_err
  );

  modport master (
    output in_valid, in_data, in_flags, out_ready,
    input  in_ready, out_valid, out_data, out_flags, count, proto_err
  );
endinterface

// File: rtl/fpu_result_skid_buffer.sv
// -----------------------------------------------------------------------------
// fpu_result_skid_buffer
//   Two-entry registered skid buffer on the FPU result path. It takes an FP32
//   result plus its exception flags (NV, DZ, OF, UF, NX) from the FPU core and
//   hands them on to the writeback/bus consumer. It breaks the combinational
//   ready path, sustains one result per cycle and keeps results in order.
//
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous active-low reset
//     bus        fpu_result_skid_buffer_if.slave (both handshakes + status)
//     dbg_state  current FSM state (0 EMPTY, 1 BUSY, 2 FULL)
//
//   Storage: the main register drives out_data/out_flags directly; the skid
//   register catches the one result that arrives while the consumer stalls.
//   in_ready and out_valid are decoded from the state register only, so there
//   is no combinational path from out_ready to in_ready or in_valid to
//   out_valid.
// -----------------------------------------------------------------------------
module fpu_result_skid_buffer #(
  parameter int WIDTH  = 32,
  parameter int FLAG_W = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  fpu_result_skid_buffer_if.slave       bus,
  output logic [1:0]                    dbg_state
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [WIDTH-1:0]  r_main_data;
  logic [FLAG_W-1:0] r_main_flags;
  logic [WIDTH-1:0]  r_skid_data;
  logic [FLAG_W-1:0] r_skid_flags;
  logic              r_stalled;    // last cycle had in_valid=1 & in_ready=0
  logic              r_proto_err;

  logic              w_in_ready;
  logic              w_out_valid;
  logic [1:0]        w_count;
  logic              w_in_fire;
  logic              w_out_fire;

  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = w_out_valid & bus.out_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (w_in_fire && !w_out_fire)      w_state_nxt = S_FULL;
        else if (!w_in_fire && w_out_fire) w_state_nxt = S_EMPTY;
        else                               w_state_nxt = S_BUSY;
      end
      S_FULL: begin
        if (w_out_fire) w_state_nxt = S_BUSY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (state register only)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_in_ready  = 1'b1;
    w_out_valid = 1'b0;
    w_count     = 2'd0;
    case (r_state)
      S_EMPTY: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        w_count     = 2'd0;
      end
      S_BUSY: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b1;
        w_count     = 2'd1;
      end
      S_FULL: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b1;
        w_count     = 2'd2;
      end
      default: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        w_count     = 2'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: main and skid registers
  //   main only loads from the input when nothing older is waiting behind it
  //   (EMPTY, or BUSY with the current head leaving). A push while the head
  //   stalls lands in skid, and skid moves up into main when FULL drains.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_data  <= '0;
      r_main_flags <= '0;
      r_skid_data  <= '0;
      r_skid_flags <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            r_main_data  <= bus.in_data;
            r_main_flags <= bus.in_flags;
          end
        end
        S_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            r_main_data  <= bus.in_data;
            r_main_flags <= bus.in_flags;
          end else if (w_in_fire) begin
            r_skid_data  <= bus.in_data;
            r_skid_flags <= bus.in_flags;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            r_main_data  <= r_skid_data;
            r_main_flags <= r_skid_flags;
          end
        end
        default: begin
          r_main_data  <= r_main_data;
          r_main_flags <= r_main_flags;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol checker: upstream must hold in_valid once it has been refused.
  // The error is sticky until reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stalled   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_stalled <= bus.in_valid & ~w_in_ready;
      if (r_stalled && !bus.in_valid) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_main_data;
  assign bus.out_flags = r_main_flags;
  assign bus.count     = w_count;
  assign bus.proto_err = r_proto_err;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_fpu_result_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_fpu_result_skid_buffer
//   Directed bench for fpu_result_skid_buffer. A table of vectors holds the
//   inputs for one clock plus the outputs expected just after that edge;
//   hand-written sequences cover the protocol-error and async-reset cases.
// -----------------------------------------------------------------------------
module tb_fpu_result_skid_buffer;

  localparam int WIDTH  = 32;
  localparam int FLAG_W = 5;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  fpu_result_skid_buffer_if #(.WIDTH(WIDTH), .FLAG_W(FLAG_W)) bus ();

  fpu_result_skid_buffer #(.WIDTH(WIDTH), .FLAG_W(FLAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic iv, input logic [WIDTH-1:0] d,
                       input logic [FLAG_W-1:0] f, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_flags  = f;
    bus.out_ready = ordy;
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic [1:0] cnt,
                              input logic ov, input logic ir, input logic perr);
    check({tag, ".count"},     32'(bus.count),     32'(cnt));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'(ir));
    check({tag, ".proto_err"}, 32'(bus.proto_err), 32'(perr));
  endtask

  task automatic check_out(input string tag, input logic [WIDTH-1:0] d,
                           input logic [FLAG_W-1:0] f);
    check({tag, ".out_data"},  32'(bus.out_data),  32'(d));
    check({tag, ".out_flags"}, 32'(bus.out_flags), 32'(f));
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    string             name;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic [FLAG_W-1:0] in_flags;
    logic              out_ready;
    logic [1:0]        exp_count;
    logic              exp_out_valid;
    logic              exp_in_ready;
    logic [WIDTH-1:0]  exp_data;
    logic [FLAG_W-1:0] exp_flags;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic iv,
                              input logic [WIDTH-1:0] d, input logic [FLAG_W-1:0] f,
                              input logic ordy, input logic [1:0] cnt,
                              input logic ov, input logic ir,
                              input logic [WIDTH-1:0] ed, input logic [FLAG_W-1:0] ef);
    vec_t v;
    v.name = name; v.in_valid = iv; v.in_data = d; v.in_flags = f;
    v.out_ready = ordy; v.exp_count = cnt; v.exp_out_valid = ov;
    v.exp_in_ready = ir; v.exp_data = ed; v.exp_flags = ef;
    vecs.push_back(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Single result; main keeps its last value after draining.
    add("single_push", 1, 32'h3F800000, 5'h00, 1, 2'd1, 1, 1, 32'h3F800000, 5'h00);
    add("single_drain", 0, 32'h0,        5'h00, 1, 2'd0, 0, 1, 32'h3F800000, 5'h00);
    // Streaming: each result visible one cycle after it is accepted.
    for (int i = 0; i < 8; i++) begin
      add($sformatf("stream%0d", i), 1, 32'h40000000 + 32'(i), 5'(i), 1,
          2'd1, 1, 1, 32'h40000000 + 32'(i), 5'(i));
    end
    add("stream_drain", 0, 32'h0, 5'h00, 1, 2'd0, 0, 1, 32'h40000007, 5'h07);
    // Fill and stall, C offered while FULL, then drain A, B, C.
    add("fill_a",   1, 32'h41200000, 5'h00, 0, 2'd1, 1, 1, 32'h41200000, 5'h00);
    add("fill_b",   1, 32'hC0A00000, 5'h01, 0, 2'd2, 1, 0, 32'h41200000, 5'h00);
    add("offer_c",  1, 32'h3F000000, 5'h10, 0, 2'd2, 1, 0, 32'h41200000, 5'h00);
    add("drain_a",  1, 32'h3F000000, 5'h10, 1, 2'd1, 1, 1, 32'hC0A00000, 5'h01);
    add("take_c",   1, 32'h3F000000, 5'h10, 1, 2'd1, 1, 1, 32'h3F000000, 5'h10);
    add("drain_c",  0, 32'h0,        5'h00, 1, 2'd0, 0, 1, 32'h3F000000, 5'h10);
    // Simultaneous in/out fire while BUSY.
    add("sim_d",    1, 32'h12345678, 5'h02, 0, 2'd1, 1, 1, 32'h12345678, 5'h02);
    add("sim_e",    1, 32'h9ABCDEF0, 5'h04, 1, 2'd1, 1, 1, 32'h9ABCDEF0, 5'h04);
    add("sim_drain",0, 32'h0,        5'h00, 1, 2'd0, 0, 1, 32'h9ABCDEF0, 5'h04);

    // Reset: low for 3 cycles.
    drive(0, '0, '0, 0);
    reset = 1'b0;
    repeat (3) tick();
    check_status("reset", 2'd0, 0, 1, 0);
    check_out("reset", 32'h0, 5'h00);
    dbg_chk: check("reset.dbg_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].in_flags, vecs[i].out_ready);
      tick();
      check_status(vecs[i].name, vecs[i].exp_count, vecs[i].exp_out_valid,
                   vecs[i].exp_in_ready, 1'b0);
      check_out(vecs[i].name, vecs[i].exp_data, vecs[i].exp_flags);
    end

    // Protocol error: FULL, in_valid held 2 stalled cycles, then withdrawn.
    drive(1, 32'h00000011, 5'h00, 0); tick();
    drive(1, 32'h00000022, 5'h00, 0); tick();
    check_status("perr_full", 2'd2, 1, 0, 0);
    drive(1, 32'h00000033, 5'h00, 0); tick();
    drive(1, 32'h00000033, 5'h00, 0); tick();
    check_status("perr_held", 2'd2, 1, 0, 0);
    drive(0, 32'h0, 5'h00, 0); tick();
    check_status("perr_set", 2'd2, 1, 0, 1);
    check_out("perr_set", 32'h00000011, 5'h00);
    drive(0, 32'h0, 5'h00, 1); tick();
    check_out("perr_drain1", 32'h00000022, 5'h00);
    tick();
    tick();
    check_status("perr_sticky", 2'd0, 0, 1, 1);

    // Async reset while FULL, asserted between clock edges.
    drive(1, 32'h000000AA, 5'h03, 0); tick();
    drive(1, 32'h000000BB, 5'h05, 0); tick();
    drive(0, 32'h0, 5'h00, 0);
    check_status("pre_rst_full", 2'd2, 1, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    check_status("async_rst", 2'd0, 0, 1, 0);
    check_out("async_rst", 32'h0, 5'h00);
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 32'h0, 5'h00, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_status($sformatf("post_rst_idle%0d", i), 2'd0, 0, 1, 0);
      check_out($sformatf("post_rst_idle%0d", i), 32'h0, 5'h00);
    end
    drive(1, 32'h000000CC, 5'h08, 1); tick();
    check_status("post_rst_push", 2'd1, 1, 1, 0);
    check_out("post_rst_push", 32'h000000CC, 5'h08);
    drive(0, 32'h0, 5'h00, 1); tick();
    check_status("post_rst_drain", 2'd0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
